// File: rtl/compute_cluster.sv
// compute_cluster: sparse 8-bit dot-product cluster.
// Shared double-buffered IFM chunk, per-unit filter chunks and accumulators.
module compute_cluster #(
  parameter int CHUNK_SIZE       = 128,
  parameter int BUS_SIZE         = 8,
  parameter int PREFIX_SUM_SIZE  = 8,
  parameter int OUTPUT_BUF_SIZE  = 32,
  parameter int OUTPUT_BUF_NUM   = 32,
  parameter int COMPUTE_UNIT_NUM = 32
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic [BUS_SIZE-1:0]                   ifm_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                 ifm_nonzero_data_i,
  input  logic                                  ifm_chunk_wr_valid_i,
  input  logic [$clog2(CHUNK_SIZE/BUS_SIZE)-1:0] ifm_chunk_wr_count_i,
  input  logic                                  ifm_chunk_wr_sel_i,
  input  logic                                  ifm_chunk_rd_sel_i,
  input  logic [BUS_SIZE-1:0]                   fil_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                 fil_nonzero_data_i,
  input  logic                                  fil_chunk_wr_valid_i,
  input  logic [$clog2(CHUNK_SIZE/BUS_SIZE)-1:0] fil_chunk_wr_count_i,
  input  logic                                  fil_chunk_wr_sel_i,
  input  logic                                  fil_chunk_rd_sel_i,
  input  logic [$clog2(COMPUTE_UNIT_NUM)-1:0]   fil_wr_order_sel_i,
  input  logic                                  init_i,
  input  logic                                  sub_chunk_start_i,
  output logic                                  sub_chunk_end_o,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]     acc_buf_sel_i,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]     out_buf_sel_i,
  input  logic [$clog2(COMPUTE_UNIT_NUM)-1:0]   com_unit_out_buf_sel_i,
  output logic [OUTPUT_BUF_SIZE-1:0]            out_buf_dat_o
);
  localparam int P    = PREFIX_SUM_SIZE;
  localparam int NWIN = CHUNK_SIZE / P;
  localparam int CW   = $clog2(CHUNK_SIZE);
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int CU   = COMPUTE_UNIT_NUM;
  localparam int BW   = $clog2(OUTPUT_BUF_NUM);
  localparam logic [WW-1:0] LAST_WIN = WW'(NWIN - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [CHUNK_SIZE-1:0]      r_ifm_map [2];
  logic [7:0]                 r_ifm_dat [2][CHUNK_SIZE];
  logic [CHUNK_SIZE-1:0]      r_fil_map [CU][2];
  logic [7:0]                 r_fil_dat [CU][2][CHUNK_SIZE];
  logic [OUTPUT_BUF_SIZE-1:0] r_acc [CU][OUTPUT_BUF_NUM];

  state_t                     r_state;
  logic                       r_init;
  logic                       r_end;
  logic                       r_ifm_rd;
  logic                       r_fil_rd;
  logic [BW-1:0]              r_acc_sel;
  logic [CHUNK_SIZE-1:0]      r_match [CU];
  logic [WW-1:0]              r_win [CU];
  logic [CU-1:0]              r_done;
  logic [OUTPUT_BUF_SIZE-1:0] r_out;

  logic                       w_start;
  logic [CW-1:0]              w_ifm_base;
  logic [CW-1:0]              w_fil_base;
  logic [P-1:0]               w_win [CU];
  logic [CU-1:0]              w_hit;
  logic [CU-1:0]              w_done_nxt;
  logic [CW-1:0]              w_pos [CU];
  logic [CW-1:0]              w_ifm_idx [CU];
  logic [CW-1:0]              w_fil_idx [CU];
  logic [15:0]                w_prod [CU];

  assign w_start    = !init_i && (sub_chunk_start_i || r_init);
  assign w_ifm_base = CW'(int'(ifm_chunk_wr_count_i) * BUS_SIZE);
  assign w_fil_base = CW'(int'(fil_chunk_wr_count_i) * BUS_SIZE);

  // Bitmap write port; bitmaps reset to empty
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < 2; s++) begin
        r_ifm_map[s] <= '0;
        for (int u = 0; u < CU; u++)
          r_fil_map[u][s] <= '0;
      end
    end else begin
      if (ifm_chunk_wr_valid_i)
        r_ifm_map[ifm_chunk_wr_sel_i][w_ifm_base +: BUS_SIZE]
          <= ifm_sparsemap_i;
      if (fil_chunk_wr_valid_i)
        r_fil_map[fil_wr_order_sel_i][fil_chunk_wr_sel_i][w_fil_base +: BUS_SIZE]
          <= fil_sparsemap_i;
    end
  end

  // Packed nonzero byte write port; contents only matter under a set bit
  always_ff @(posedge CLK) begin
    for (int b = 0; b < BUS_SIZE; b++) begin
      if (ifm_chunk_wr_valid_i)
        r_ifm_dat[ifm_chunk_wr_sel_i][w_ifm_base + CW'(b)]
          <= ifm_nonzero_data_i[b*8 +: 8];
      if (fil_chunk_wr_valid_i)
        r_fil_dat[fil_wr_order_sel_i][fil_chunk_wr_sel_i][w_fil_base + CW'(b)]
          <= fil_nonzero_data_i[b*8 +: 8];
    end
  end

  // Per-unit scan: lowest match in window, packed byte offsets, product
  always_comb begin
    for (int u = 0; u < CU; u++) begin
      w_win[u] = r_match[u][CW'(int'(r_win[u]) * P) +: P];
      w_hit[u] = |w_win[u];
      w_pos[u] = '0;
      for (int b = P - 1; b >= 0; b--)
        if (w_win[u][b]) w_pos[u] = CW'(int'(r_win[u]) * P + b);
      w_ifm_idx[u] = '0;
      w_fil_idx[u] = '0;
      for (int b = 0; b < CHUNK_SIZE; b++) begin
        if (b < int'(w_pos[u])) begin
          if (r_ifm_map[r_ifm_rd][b])
            w_ifm_idx[u] = w_ifm_idx[u] + CW'(1);
          if (r_fil_map[u][r_fil_rd][b])
            w_fil_idx[u] = w_fil_idx[u] + CW'(1);
        end
      end
      w_prod[u] = 16'(r_ifm_dat[r_ifm_rd][w_ifm_idx[u]])
                * 16'(r_fil_dat[u][r_fil_rd][w_fil_idx[u]]);
      w_done_nxt[u] = r_done[u] || (!w_hit[u] && r_win[u] == LAST_WIN);
    end
  end

  // Sequencer: latch on start, step windows, pulse end when all units finish
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_init    <= 1'b0;
      r_end     <= 1'b0;
      r_ifm_rd  <= 1'b0;
      r_fil_rd  <= 1'b0;
      r_acc_sel <= '0;
      r_done    <= '1;
      for (int u = 0; u < CU; u++) begin
        r_match[u] <= '0;
        r_win[u]   <= '0;
      end
    end else begin
      r_init <= init_i;
      r_end  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_RUN;
            r_ifm_rd  <= ifm_chunk_rd_sel_i;
            r_fil_rd  <= fil_chunk_rd_sel_i;
            r_acc_sel <= acc_buf_sel_i;
            r_done    <= '0;
            for (int u = 0; u < CU; u++) begin
              r_match[u] <= r_ifm_map[ifm_chunk_rd_sel_i]
                          & r_fil_map[u][fil_chunk_rd_sel_i];
              r_win[u]   <= '0;
            end
          end
        end
        S_RUN: begin
          for (int u = 0; u < CU; u++) begin
            if (!r_done[u]) begin
              if (w_hit[u])
                r_match[u][w_pos[u]] <= 1'b0;
              else if (r_win[u] != LAST_WIN)
                r_win[u] <= r_win[u] + WW'(1);
            end
          end
          r_done <= w_done_nxt;
          if (&w_done_nxt) begin
            r_end   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Accumulators: init clears every cycle, otherwise one MAC per busy unit
  always_ff @(posedge CLK) begin
    if (RESET || init_i) begin
      for (int u = 0; u < CU; u++)
        for (int b = 0; b < OUTPUT_BUF_NUM; b++)
          r_acc[u][b] <= '0;
    end else if (r_state == S_RUN) begin
      for (int u = 0; u < CU; u++)
        if (!r_done[u] && w_hit[u])
          r_acc[u][r_acc_sel] <= r_acc[u][r_acc_sel]
                               + OUTPUT_BUF_SIZE'(w_prod[u]);
    end
  end

  // Registered readback mux
  always_ff @(posedge CLK) begin
    if (RESET) r_out <= '0;
    else       r_out <= r_acc[com_unit_out_buf_sel_i][out_buf_sel_i];
  end

  assign out_buf_dat_o   = r_out;
  assign sub_chunk_end_o = r_end;

endmodule

// File: tb/tb_compute_cluster.sv
// tb_compute_cluster: randomized check of compute_cluster against
// a dense dot-product scoreboard.
module tb_compute_cluster;
  localparam int CS = 128;
  localparam int NU = 32;
  localparam int NB = 32;
  localparam int AW = 16;
  localparam longint MASK = (64'd1 << AW) - 1;

  logic          CLK;
  logic          RESET;
  logic [7:0]    ifm_sparsemap_i;
  logic [63:0]   ifm_nonzero_data_i;
  logic          ifm_chunk_wr_valid_i;
  logic [3:0]    ifm_chunk_wr_count_i;
  logic          ifm_chunk_wr_sel_i;
  logic          ifm_chunk_rd_sel_i;
  logic [7:0]    fil_sparsemap_i;
  logic [63:0]   fil_nonzero_data_i;
  logic          fil_chunk_wr_valid_i;
  logic [3:0]    fil_chunk_wr_count_i;
  logic          fil_chunk_wr_sel_i;
  logic          fil_chunk_rd_sel_i;
  logic [4:0]    fil_wr_order_sel_i;
  logic          init_i;
  logic          sub_chunk_start_i;
  logic          sub_chunk_end_o;
  logic [4:0]    acc_buf_sel_i;
  logic [4:0]    out_buf_sel_i;
  logic [4:0]    com_unit_out_buf_sel_i;
  logic [AW-1:0] out_buf_dat_o;

  compute_cluster #(
    .OUTPUT_BUF_SIZE(AW)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ifm_sparsemap_i(ifm_sparsemap_i),
    .ifm_nonzero_data_i(ifm_nonzero_data_i),
    .ifm_chunk_wr_valid_i(ifm_chunk_wr_valid_i),
    .ifm_chunk_wr_count_i(ifm_chunk_wr_count_i),
    .ifm_chunk_wr_sel_i(ifm_chunk_wr_sel_i),
    .ifm_chunk_rd_sel_i(ifm_chunk_rd_sel_i),
    .fil_sparsemap_i(fil_sparsemap_i),
    .fil_nonzero_data_i(fil_nonzero_data_i),
    .fil_chunk_wr_valid_i(fil_chunk_wr_valid_i),
    .fil_chunk_wr_count_i(fil_chunk_wr_count_i),
    .fil_chunk_wr_sel_i(fil_chunk_wr_sel_i),
    .fil_chunk_rd_sel_i(fil_chunk_rd_sel_i),
    .fil_wr_order_sel_i(fil_wr_order_sel_i),
    .init_i(init_i),
    .sub_chunk_start_i(sub_chunk_start_i),
    .sub_chunk_end_o(sub_chunk_end_o),
    .acc_buf_sel_i(acc_buf_sel_i),
    .out_buf_sel_i(out_buf_sel_i),
    .com_unit_out_buf_sel_i(com_unit_out_buf_sel_i),
    .out_buf_dat_o(out_buf_dat_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] ifm_d [2][CS];
  logic [7:0] fil_d [NU][2][CS];
  longint     acc_m [NU][NB];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint dot(input int u, input int is, input int fs);
    longint s = 0;
    for (int j = 0; j < CS; j++)
      s += longint'(ifm_d[is][j]) * longint'(fil_d[u][fs][j]);
    return s;
  endfunction

  // Slowest unit spends (matches + windows) cycles; end follows one later.
  function automatic int lat(input int is, input int fs);
    int m = 0;
    for (int u = 0; u < NU; u++) begin
      int c = 0;
      for (int j = 0; j < CS; j++)
        if (ifm_d[is][j] != 0 && fil_d[u][fs][j] != 0) c++;
      if (c > m) m = c;
    end
    return m + CS / 8 + 1;
  endfunction

  task automatic clear_model();
    for (int u = 0; u < NU; u++)
      for (int b = 0; b < NB; b++) acc_m[u][b] = 0;
  endtask

  task automatic send(input bit is_fil, input int u, input int slot);
    logic [7:0]    d [CS];
    logic [7:0]    pk [CS];
    logic [CS-1:0] m;
    int c;
    c = 0;
    m = '0;
    for (int j = 0; j < CS; j++) begin
      d[j]  = is_fil ? fil_d[u][slot][j] : ifm_d[slot][j];
      pk[j] = 8'd0;
    end
    for (int j = 0; j < CS; j++)
      if (d[j] != 0) begin
        m[j] = 1'b1;
        pk[c] = d[j];
        c++;
      end
    for (int k = 0; k < CS / 8; k++) begin
      if (is_fil) begin
        fil_chunk_wr_valid_i = 1'b1;
        fil_chunk_wr_count_i = 4'(k);
        fil_chunk_wr_sel_i   = slot[0];
        fil_wr_order_sel_i   = 5'(u);
        fil_sparsemap_i      = m[k*8 +: 8];
        for (int b = 0; b < 8; b++)
          fil_nonzero_data_i[b*8 +: 8] = pk[k*8 + b];
      end else begin
        ifm_chunk_wr_valid_i = 1'b1;
        ifm_chunk_wr_count_i = 4'(k);
        ifm_chunk_wr_sel_i   = slot[0];
        ifm_sparsemap_i      = m[k*8 +: 8];
        for (int b = 0; b < 8; b++)
          ifm_nonzero_data_i[b*8 +: 8] = pk[k*8 + b];
      end
      @(posedge CLK); #1;
    end
    if (is_fil) fil_chunk_wr_valid_i = 1'b0;
    else        ifm_chunk_wr_valid_i = 1'b0;
  endtask

  task automatic run_chunk(input int is, input int fs, input int ab,
                           input bit use_init, input bit glitch);
    int exp_lat;
    int n;
    exp_lat = lat(is, fs);
    ifm_chunk_rd_sel_i = is[0];
    fil_chunk_rd_sel_i = fs[0];
    acc_buf_sel_i      = 5'(ab);
    if (use_init) init_i = 1'b0;
    else          sub_chunk_start_i = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); #1;
      sub_chunk_start_i = 1'b0;
      n++;
      if (glitch && n == 5) sub_chunk_start_i = 1'b1;
    end while (!sub_chunk_end_o && n < 400);
    check($sformatf("lat_b%0d", ab), n, exp_lat);
    for (int u = 0; u < NU; u++)
      acc_m[u][ab] = (acc_m[u][ab] + dot(u, is, fs)) & MASK;
    @(posedge CLK); #1;
    check($sformatf("endpulse_b%0d", ab), sub_chunk_end_o, 0);
  endtask

  task automatic rd(input int u, input int b);
    com_unit_out_buf_sel_i = 5'(u);
    out_buf_sel_i          = 5'(b);
    @(posedge CLK); #1;
    check($sformatf("acc_u%0d_b%0d", u, b), out_buf_dat_o, acc_m[u][b]);
  endtask

  initial begin
    bit seen;
    RESET = 1'b1;
    ifm_sparsemap_i = '0;
    ifm_nonzero_data_i = '0;
    ifm_chunk_wr_valid_i = 1'b0;
    ifm_chunk_wr_count_i = '0;
    ifm_chunk_wr_sel_i = 1'b0;
    ifm_chunk_rd_sel_i = 1'b0;
    fil_sparsemap_i = '0;
    fil_nonzero_data_i = '0;
    fil_chunk_wr_valid_i = 1'b0;
    fil_chunk_wr_count_i = '0;
    fil_chunk_wr_sel_i = 1'b0;
    fil_chunk_rd_sel_i = 1'b0;
    fil_wr_order_sel_i = '0;
    init_i = 1'b0;
    sub_chunk_start_i = 1'b0;
    acc_buf_sel_i = '0;
    out_buf_sel_i = '0;
    com_unit_out_buf_sel_i = '0;
    for (int s = 0; s < 2; s++)
      for (int j = 0; j < CS; j++) begin
        ifm_d[s][j] = 8'd0;
        for (int u = 0; u < NU; u++) fil_d[u][s][j] = 8'd0;
      end
    clear_model();

    repeat (50) @(posedge CLK);
    #1;
    check("rst_out", out_buf_dat_o, 0);
    check("rst_end", sub_chunk_end_o, 0);
    RESET = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      if (sub_chunk_end_o) seen = 1;
    end
    check("idle_noend", seen, 0);
    rd(3, 7);

    init_i = 1'b1;
    fil_d[0][0][5] = 8'd3;
    send(1, 0, 0);
    ifm_d[0][5] = 8'd7;
    send(0, 0, 0);
    run_chunk(0, 0, 0, 1, 0);
    rd(0, 0);
    check("single_const", out_buf_dat_o, 21);
    rd(1, 0);

    ifm_d[1][6] = 8'd9;
    send(0, 0, 1);
    run_chunk(1, 0, 1, 0, 0);
    rd(0, 1);
    rd(0, 0);

    init_i = 1'b1;
    clear_model();
    for (int u = 0; u < NU; u++) begin
      for (int j = 0; j < CS; j++)
        fil_d[u][1][j] = ($urandom_range(99) < 70) ?
                         8'($urandom_range(255, 1)) : 8'd0;
      send(1, u, 1);
    end
    begin
      int d0;
      d0 = $urandom_range(100);
      for (int j = 0; j < CS; j++)
        ifm_d[0][j] = ($urandom_range(99) < d0) ?
                      8'($urandom_range(255, 1)) : 8'd0;
    end
    send(0, 0, 0);

    for (int i = 0; i < 31; i++) begin
      int cs;
      int ns;
      int dn;
      cs = i % 2;
      ns = (i + 1) % 2;
      if (i < 30) begin
        dn = $urandom_range(100);
        for (int j = 0; j < CS; j++)
          ifm_d[ns][j] = ($urandom_range(99) < dn) ?
                         8'($urandom_range(255, 1)) : 8'd0;
      end
      fork
        run_chunk(cs, 1, i, i == 0, i % 2 == 1);
        if (i < 30) send(0, 0, ns);
      join
    end
    for (int u = 0; u < NU; u++)
      for (int b = 0; b < 31; b++) rd(u, b);

    for (int j = 0; j < CS; j++) begin
      ifm_d[1][j] = 8'd255;
      for (int u = 0; u < 4; u++) fil_d[u][0][j] = 8'd255;
    end
    send(0, 0, 1);
    for (int u = 0; u < 4; u++) send(1, u, 0);
    run_chunk(1, 0, 31, 0, 0);
    run_chunk(1, 0, 31, 0, 0);
    rd(0, 31);
    check("wrap_const", out_buf_dat_o, (2 * 128 * 65025) % 65536);
    rd(3, 31);
    rd(4, 31);
    rd(5, 0);

    ifm_chunk_rd_sel_i = 1'b1;
    fil_chunk_rd_sel_i = 1'b0;
    sub_chunk_start_i = 1'b1;
    @(posedge CLK); #1;
    sub_chunk_start_i = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RESET = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      check("midrst_end", sub_chunk_end_o, 0);
    end
    RESET = 1'b0;
    clear_model();
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge CLK); #1;
      if (sub_chunk_end_o) seen = 1;
    end
    check("midrst_noend", seen, 0);
    rd(0, 31);
    rd(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
